mem_port_arbiter: RTL

- Shares the single-ported unified memory between the instruction-fetch path and the load/store data path.
- Each requester raises a level request and receives a one-cycle acknowledge with read data.
- One memory transaction is in flight at a time; `o_stall` freezes the pipeline while any request is outstanding.
- Sits between the fetch unit, the `o_Mem_Read`/`o_Mem_Write` data path and the memory wrapper.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and load/store paths.
// Build option: define ARB_ROUND_ROBIN_EN for alternating priority instead of data-first with starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stall
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t            r_state;
  logic              r_owner_d;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // Resets to "fetch was last" so data wins the first contested grant.
  always_comb begin
    w_pick_d = i_d_req & (~i_if_req | ~r_last_d);
  end
`else
  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);
  logic [3:0] r_starve;

  always_comb begin
    w_pick_d = i_d_req & ~(i_if_req & (r_starve == LP_STARVE_MAX));
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_owner_d   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_d    <= 1'b0;
`else
      r_starve    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
          if (!i_if_req) begin
            r_starve <= '0;
          end
`endif
          if (i_if_req | i_d_req) begin
            r_state     <= S_BUS;
            r_mem_req   <= 1'b1;
            r_owner_d   <= w_pick_d;
            r_mem_we    <= w_pick_d & i_d_we;
            r_mem_addr  <= w_pick_d ? i_d_addr : i_if_addr;
            r_mem_wdata <= w_pick_d ? i_d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d    <= w_pick_d;
`else
            if (!w_pick_d) begin
              r_starve <= '0;
            end else if (i_if_req && (r_starve != LP_STARVE_MAX)) begin
              r_starve <= r_starve + 4'd1;
            end
`endif
          end
        end
        S_BUS: begin
          if (i_mem_ack) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            if (r_owner_d) begin
              r_d_ack <= 1'b1;
              if (!r_mem_we) begin
                r_d_rdata <= i_mem_rdata;
              end
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= i_mem_rdata;
            end
          end
        end
        S_DONE: begin
          r_if_ack <= 1'b0;
          r_d_ack  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_if_ack    = r_if_ack;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_ack     = r_d_ack;
  assign o_d_rdata   = r_d_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_stall     = (i_if_req & ~r_if_ack) | (i_d_req & ~r_d_ack);

endmodule
